i2s_pcm_capture: RTL
====================

Name: i2s_pcm_capture

Overview:
- Sits directly downstream of the S/PDIF decoder.
- Consumes the decoder's i2s_bck / i2s_ws / i2s_d0 stream and audio_locked flag.
- Deserialises each left/right channel slot into parallel words and presents stereo pairs on a valid/ready handshake for the DSP/FIFO stage.
- Runs on the same clk_in as the decoder and oversamples bck.

Parameters:
DATA_W, 24, captured word width per channel (8..32)
LSB_FIRST, 0, 1 = first bit of a slot is the word LSB (raw S/PDIF order); 0 = MSB first
SYNC_STAGES, 2, synchroniser depth on bck/ws/d0 (>=1)

Ports:
clk_in  input  1  system clock, single clock domain
reset  input  1  synchronous, active-high reset
i2s_bck  input  1  bit clock from decoder (oversampled, not used as clock)
i2s_ws  input  1  word select: 0 = left, 1 = right
i2s_d0  input  1  serial data
audio_locked  input  1  decoder lock; low forces resync
pcm_left  output  DATA_W  captured left word of last emitted pair
pcm_right  output  DATA_W  captured right word of last emitted pair
pcm_valid  output  1  pair available, held until accepted
pcm_ready  input  1  consumer accepts pair when valid&ready
frame_err  output  1  one-cycle pulse: short slot detected
overrun  output  1  sticky: completed pair dropped due to backpressure

Behaviour:
- Reset: all outputs 0; state IDLE; shift register, bit counter and synchronisers cleared.
- Input path:
  - bck, ws and d0 each pass through SYNC_STAGES flops.
  - A bck rise is detected as synced bck = 1 while the previous synced bck = 0.
  - ws_s and d_s are sampled on that cycle; ws_p holds the ws value from the previous bck rise.
  - Requirement on the source: bck high and low phases each >= SYNC_STAGES+1 clk_in cycles.
- Bit counter: 6 bits, saturates at 63.
  - Only the first DATA_W bits of a slot are shifted in; later bits are counted but ignored.
- Shift rule:
  - MSB first: sr <= {sr[DATA_W-2:0], d_s}.
  - LSB_FIRST: sr <= {d_s, sr[DATA_W-1:1]}.
- Slot start: the bit sampled at the bck rise where ws_s != ws_p is bit 0 of the new slot. There is no one-bit I2S delay.
- FSM (all transitions only on bck-rise cycles, except the lock-drop rule):
  - IDLE:
    - Wait for audio_locked = 1 and ws_p = 1, ws_s = 0.
    - Then go to LEFT with cnt = 1 and shift the first bit.
  - LEFT:
    - While ws_s = 0: shift and increment cnt.
    - On ws_s = 1: if cnt >= DATA_W, copy sr to left_hold and set left_ok = 1; otherwise set left_ok = 0 and pulse frame_err.
    - Then go to RIGHT with cnt = 1, first right bit shifted into a cleared sr.
  - RIGHT:
    - While ws_s = 1: shift and increment cnt.
    - On ws_s = 0: if cnt >= DATA_W and left_ok = 1, emit the pair (left_hold, sr).
    - If cnt < DATA_W: pulse frame_err, no emit.
    - If left_ok = 0 (and cnt >= DATA_W): no emit, no second error pulse.
    - Then go to LEFT with cnt = 1, first bit shifted.
  - Lock drop: audio_locked = 0 on any cycle forces IDLE next cycle.
    - cnt, sr and left_ok are cleared; no emit, no frame_err.
    - pcm_left, pcm_right, pcm_valid and overrun are unaffected.
- Emit and handshake:
  - Emit on the clock after the detecting bck rise: pcm_left/pcm_right load and pcm_valid = 1.
  - pcm_valid clears on the cycle after valid & ready, unless a new emit occurs the same cycle; then the new pair loads and valid stays 1.
  - Emit while valid & !ready: the pair is dropped, outputs stay unchanged, overrun is set.
  - overrun is sticky and cleared only by reset.
  - pcm_left/pcm_right are stable whenever pcm_valid = 1.
- Latency: pin-level bck rise ending the right slot -> pcm_valid high after SYNC_STAGES+2 clk_in cycles.
- Reset mid-slot: reset takes priority over all updates; partial words are discarded.

Test Plan:
- Reset: hold reset 3 cycles with toggling inputs -> all outputs 0, no valid.
- Nominal (DATA_W = 24, MSB first, bck half-period 17 clk, 24-bit slots, pcm_ready = 1): L = 0xA5C3F0, R = 0x123456 -> one pcm_valid with pcm_left = 0xA5C3F0, pcm_right = 0x123456; no frame_err; 2nd frame L = 0x000001, R = 0xFFFFFF emits correctly.
- LSB_FIRST = 1: stream 0xA5C3F0 LSB first -> pcm_left = 0xA5C3F0; 32-bit slots with 8 trailing junk bits -> words unchanged.
- Short slot: left slot of 20 bits -> frame_err single pulse, that pair not emitted, next full pair emitted normally.
- Backpressure: pcm_ready = 0 across two frames -> first pair held valid, second dropped, overrun = 1; raise ready -> valid drops, overrun stays 1.
- Lock drop: deassert audio_locked mid-left slot, reassert -> no emit until the next ws 1->0 boundary, then the correct pair is emitted; reset mid-right-slot -> no emit, outputs 0.

Source files
------------

// File: rtl/i2s_pcm_capture.sv
// I2S-style slot deserialiser behind the S/PDIF decoder: oversamples bck/ws/d0 on clk_in,
// assembles left/right words and offers stereo pairs on a valid/ready handshake.
module i2s_pcm_capture #(
   parameter int DATA_W      = 24,
   parameter bit LSB_FIRST   = 1'b0,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic              i2s_bck,
   input  logic              i2s_ws,
   input  logic              i2s_d0,
   input  logic              audio_locked,
   output logic [DATA_W-1:0] pcm_left,
   output logic [DATA_W-1:0] pcm_right,
   output logic              pcm_valid,
   input  logic              pcm_ready,
   output logic              frame_err,
   output logic              overrun
);

   // Handshake: a pair transfers on any clk_in edge where pcm_valid & pcm_ready; pcm_valid
   // never drops and pcm_left/pcm_right never change while a pair is waiting for acceptance.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } state_t;

   localparam logic [6:0] WORD_BITS = 7'(DATA_W);

   logic [SYNC_STAGES-1:0] bck_sync;
   logic [SYNC_STAGES-1:0] ws_sync;
   logic [SYNC_STAGES-1:0] d_sync;
   logic                   bck_s;
   logic                   bck_q;
   logic                   ws_s;
   logic                   d_s;
   logic                   ws_p;
   logic                   bck_rise;

   state_t                 state_q;
   state_t                 state_d;
   logic [5:0]             cnt_q;
   logic [5:0]             cnt_d;
   logic [DATA_W-1:0]      sr_q;
   logic [DATA_W-1:0]      sr_d;
   logic [DATA_W-1:0]      left_hold_q;
   logic [DATA_W-1:0]      left_hold_d;
   logic                   left_ok_q;
   logic                   left_ok_d;
   logic                   emit_d;
   logic                   frame_err_d;
   logic                   cnt_full;

   logic                   emit_q;
   logic [DATA_W-1:0]      emit_left_q;
   logic [DATA_W-1:0]      emit_right_q;

   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v,
                                                  input logic              b);
      if (LSB_FIRST)
         return {b, v[DATA_W-1:1]};
      else
         return {v[DATA_W-2:0], b};
   endfunction

   function automatic logic [5:0] cnt_inc(input logic [5:0] c);
      return (c == 6'd63) ? c : c + 6'd1;
   endfunction

   always_ff @(posedge clk_in) begin
      if (reset) begin
         bck_sync <= '0;
         ws_sync  <= '0;
         d_sync   <= '0;
         bck_q    <= 1'b0;
         ws_p     <= 1'b0;
      end else begin
         bck_sync[0] <= i2s_bck;
         ws_sync[0]  <= i2s_ws;
         d_sync[0]   <= i2s_d0;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            bck_sync[i] <= bck_sync[i-1];
            ws_sync[i]  <= ws_sync[i-1];
            d_sync[i]   <= d_sync[i-1];
         end
         bck_q <= bck_s;
         if (bck_rise)
            ws_p <= ws_s;
      end
   end

   assign bck_s    = bck_sync[SYNC_STAGES-1];
   assign ws_s     = ws_sync[SYNC_STAGES-1];
   assign d_s      = d_sync[SYNC_STAGES-1];
   assign bck_rise = bck_s & ~bck_q;
   assign cnt_full = ({1'b0, cnt_q} >= WORD_BITS);

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sr_q        <= '0;
         left_hold_q <= '0;
         left_ok_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sr_q        <= sr_d;
         left_hold_q <= left_hold_d;
         left_ok_q   <= left_ok_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sr_d        = sr_q;
      left_hold_d = left_hold_q;
      left_ok_d   = left_ok_q;
      emit_d      = 1'b0;
      frame_err_d = 1'b0;

      if (!audio_locked) begin
         state_d   = IDLE;
         cnt_d     = '0;
         sr_d      = '0;
         left_ok_d = 1'b0;
      end else if (bck_rise) begin
         case (state_q)
            IDLE: begin
               if (ws_p && !ws_s) begin
                  state_d = LEFT;
                  cnt_d   = 6'd1;
                  sr_d    = shift_in('0, d_s);
               end
            end

            LEFT: begin
               if (!ws_s) begin
                  // Bits beyond the word width are counted but not shifted.
                  if (!cnt_full)
                     sr_d = shift_in(sr_q, d_s);
                  cnt_d = cnt_inc(cnt_q);
               end else begin
                  if (cnt_full) begin
                     left_hold_d = sr_q;
                     left_ok_d   = 1'b1;
                  end else begin
                     left_ok_d   = 1'b0;
                     frame_err_d = 1'b1;
                  end
                  state_d = RIGHT;
                  cnt_d   = 6'd1;
                  sr_d    = shift_in('0, d_s);
               end
            end

            RIGHT: begin
               if (ws_s) begin
                  if (!cnt_full)
                     sr_d = shift_in(sr_q, d_s);
                  cnt_d = cnt_inc(cnt_q);
               end else begin
                  // A short left slot already raised its error; only the right length is judged here.
                  if (!cnt_full)
                     frame_err_d = 1'b1;
                  else if (left_ok_q)
                     emit_d = 1'b1;
                  state_d = LEFT;
                  cnt_d   = 6'd1;
                  sr_d    = shift_in('0, d_s);
               end
            end

            default: begin
               state_d   = IDLE;
               cnt_d     = '0;
               sr_d      = '0;
               left_ok_d = 1'b0;
            end
         endcase
      end
   end

   // Completed pair is staged one cycle, then offered to the consumer.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         emit_q       <= 1'b0;
         emit_left_q  <= '0;
         emit_right_q <= '0;
         frame_err    <= 1'b0;
      end else begin
         emit_q    <= emit_d;
         frame_err <= frame_err_d;
         if (emit_d) begin
            emit_left_q  <= left_hold_q;
            emit_right_q <= sr_q;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         pcm_left  <= '0;
         pcm_right <= '0;
         pcm_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (emit_q) begin
            if (!pcm_valid || pcm_ready) begin
               pcm_left  <= emit_left_q;
               pcm_right <= emit_right_q;
               pcm_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (pcm_valid && pcm_ready) begin
            pcm_valid <= 1'b0;
         end
      end
   end

endmodule
